// File: rtl/imem_responder.sv
// imem_responder: fixed-latency line-fill responder for the icache miss path; optional range checking via IMEM_RANGE_CHK_EN
module imem_responder #(
  parameter int ADDR_W  = 20,
  parameter int LINE_W  = 128,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [LINE_W-1:0] resp_data,
`ifdef IMEM_RANGE_CHK_EN
  output logic              resp_err,
`endif
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [31:0]       ld_data
);
  localparam int OFF = $clog2(LINE_W / 8);
  localparam int IDX = $clog2(DEPTH);
  localparam int WPL = LINE_W / 32;
  localparam int WB  = WPL > 1 ? $clog2(WPL) : 1;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [IDX-1:0]    line_q, line_d;
  logic [LINE_W-1:0] resp_data_q, resp_data_d;
  logic [LINE_W-1:0] mem_q [DEPTH];
  logic [IDX-1:0]    req_line, ld_line;
  logic [WB-1:0]     ld_word;
  logic              ld_we;
  assign req_line = IDX'(req_addr >> OFF);
  assign ld_line  = IDX'(ld_addr >> OFF);
  assign ld_word  = WPL > 1 ? WB'(ld_addr >> 2) : '0;
`ifdef IMEM_RANGE_CHK_EN
  logic err_q, err_d, resp_err_q, resp_err_d;
  assign ld_we    = ld_en && (ld_addr >> (OFF + IDX)) == '0;
  assign resp_err = resp_err_q;
`else
  assign ld_we    = ld_en;
`endif
  assign req_ready  = state_q == IDLE;
  assign resp_valid = state_q == RESP;
  assign resp_data  = resp_data_q;
  // preload port: word write into the line array, readers see it from the next cycle
  always_ff @(posedge clk)
    if (ld_we) mem_q[ld_line][ld_word*32 +: 32] <= ld_data;
  // accept one request, count down the access latency, then hold the line until taken
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    line_d      = line_q;
    resp_data_d = resp_data_q;
`ifdef IMEM_RANGE_CHK_EN
    err_d       = err_q;
    resp_err_d  = resp_err_q;
`endif
    case (state_q)
      IDLE: if (req_valid) begin
        line_d  = req_line;
        cnt_d   = 8'(LATENCY - 1);
        state_d = WAIT;
`ifdef IMEM_RANGE_CHK_EN
        err_d   = (req_addr >> (OFF + IDX)) != '0;
`endif
      end
      WAIT: if (cnt_q == '0) begin
`ifdef IMEM_RANGE_CHK_EN
        resp_data_d = err_q ? '0 : mem_q[line_q];
        resp_err_d  = err_q;
`else
        resp_data_d = mem_q[line_q];
`endif
        state_d     = RESP;
      end else cnt_d = cnt_q - 8'd1;
      RESP: if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // control and response registers; reset drops any transaction in flight
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      line_q      <= '0;
      resp_data_q <= '0;
`ifdef IMEM_RANGE_CHK_EN
      err_q       <= 1'b0;
      resp_err_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      line_q      <= line_d;
      resp_data_q <= resp_data_d;
`ifdef IMEM_RANGE_CHK_EN
      err_q       <= err_d;
      resp_err_q  <= resp_err_d;
`endif
    end
endmodule

// File: tb/tb_imem_responder.sv
// tb_imem_responder: directed checks of latency, backpressure, busy requests, preload ordering, aliasing and reset
module tb_imem_responder;
  logic clk = 0, rst = 0, req_valid = 0, resp_ready = 0, ld_en = 0;
  logic req_ready, resp_valid;
  logic [19:0] req_addr = '0, ld_addr = '0;
  logic [31:0] ld_data = '0;
  logic [127:0] resp_data;
  int errors = 0, checks = 0;
`ifdef IMEM_RANGE_CHK_EN
  logic resp_err;
`endif
  localparam logic [127:0] L0  = {4{32'h00100093}};
  localparam logic [127:0] L0N = {32'h00100093, 32'h00100093, 32'hDEADBEEF, 32'h00100093};
  localparam logic [127:0] L1  = {32'h44440003, 32'h33330002, 32'h22220001, 32'h11110000};
  localparam logic [127:0] L1N = {32'h44440003, 32'h33330002, 32'h22220001, 32'hCAFE0000};
  always #5 clk = ~clk;
  imem_responder dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
`ifdef IMEM_RANGE_CHK_EN
    .resp_err(resp_err),
`endif
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
  );
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic load(input logic [19:0] a, input logic [31:0] d);
    ld_en = 1; ld_addr = a; ld_data = d;
    step();
    ld_en = 0;
  endtask
  task automatic request(input logic [19:0] a);
    req_valid = 1; req_addr = a;
    step();
    req_valid = 0;
  endtask
  initial begin
    step(2);
    chk("rst_ready", req_ready, 1);
    chk("rst_valid", resp_valid, 0);
    chk("rst_data", resp_data, 0);
    rst = 1;
    resp_ready = 1;
    for (int i = 0; i < 4; i++) load(20'(4 * i), 32'h00100093);
    load(20'h10, 32'h11110000);
    load(20'h14, 32'h22220001);
    load(20'h18, 32'h33330002);
    load(20'h1C, 32'h44440003);
    request(20'h8);
    chk("acc_busy", req_ready, 0);
    step(3);
    chk("wait_novalid", resp_valid, 0);
    step();
    chk("lat_valid", resp_valid, 1);
    chk("lat_data", resp_data, L0);
    chk("lat_busy", req_ready, 0);
    step();
    chk("lat_drop", resp_valid, 0);
    chk("lat_ready", req_ready, 1);
    resp_ready = 0;
    request(20'h10);
    step(4);
    for (int i = 0; i < 10; i++) begin
      if (i == 0) begin ld_en = 1; ld_addr = 20'h10; ld_data = 32'hCAFE0000; end
      chk("bp_valid", resp_valid, 1);
      chk("bp_data", resp_data, L1);
      chk("bp_ready", req_ready, 0);
      step();
      ld_en = 0;
    end
    chk("bp_hold_end", resp_data, L1);
    resp_ready = 1;
    step();
    chk("bp_release", resp_valid, 0);
    req_valid = 1; req_addr = 20'h0;
    step();
    chk("busy_acc1", req_ready, 0);
    req_addr = 20'h10;
    step(4);
    chk("busy_first", resp_data, L0);
    chk("busy_hold", req_ready, 0);
    step();
    chk("busy_idle_ready", req_ready, 1);
    chk("busy_idle_valid", resp_valid, 0);
    step();
    chk("busy_acc2", req_ready, 0);
    req_valid = 0;
    step(3);
    chk("busy_wait", resp_valid, 0);
    step();
    chk("busy_valid2", resp_valid, 1);
    chk("busy_data2", resp_data, L1N);
    step();
    request(20'h0);
    step(3);
    ld_en = 1; ld_addr = 20'h4; ld_data = 32'hDEADBEEF;
    step();
    ld_en = 0;
    chk("sc_valid", resp_valid, 1);
    chk("sc_old", resp_data, L0);
    step();
    request(20'h0);
    step(4);
    chk("sc_new", resp_data, L0N);
    step();
    request(20'h4000);
    step(4);
    chk("alias_valid", resp_valid, 1);
`ifdef IMEM_RANGE_CHK_EN
    chk("range_err", resp_err, 1);
    chk("range_data", resp_data, 0);
`else
    chk("alias_data", resp_data, L0N);
`endif
    step();
    request(20'h10);
    step();
    rst = 0;
    #1;
    chk("mid_rst_valid", resp_valid, 0);
    chk("mid_rst_ready", req_ready, 1);
    chk("mid_rst_data", resp_data, 0);
    step();
    rst = 1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("post_rst_valid", resp_valid, 0);
      chk("post_rst_ready", req_ready, 1);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
